downstream_drain: RTL and testbench
===================================

# downstream_drain

Reader side of the downstream cancelled-order accumulator RAM. On a start pulse it scans every client index, reads each accumulated 128-bit total, and emits non-zero totals as `{client, value}` transactions on a valid/ready stream. After each accepted transaction it issues a decrement write of exactly the sent amount, so accumulation that races the drain is never lost. It sits between the accumulator RAM's read/decrement ports and the downstream reporting logic.

## Interface
- `DEPTH`, 1024, number of client entries scanned
- `IDX_W`, 10, index width, equal to $clog2(DEPTH)
- `DATA_W`, 128, accumulated value width, matching `cache_data_type`
- `clk`  in  1  sole clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  single-cycle scan request
- `busy`  out  1  high from the cycle after an accepted start until `done`
- `done`  out  1  one-cycle pulse at scan end
- `rd_index`  out  IDX_W  RAM read address
- `rd_data`  in  DATA_W  RAM read data, combinational from `rd_index`
- `dec_we`  out  1  decrement strobe to RAM, one cycle
- `dec_index`  out  IDX_W  entry to decrement
- `dec_value`  out  DATA_W  amount to subtract
- `out_valid`  out  1  transaction valid
- `out_ready`  in  1  consumer accepts
- `out_client`  out  IDX_W  client id of transaction
- `out_value`  out  DATA_W  total for that client
- `sent_count`  out  16  transactions accepted in the current or last scan

## Operation
- States: IDLE, READ, SEND, CLEAR, DONE.
- IDLE: `start`=1 -> READ, idx=0, `sent_count`=0. All other inputs ignored.
- READ: `rd_index`=idx; `rd_data` is latched into val_q at the edge. If `rd_data`==0: idx==DEPTH-1 -> DONE, otherwise idx+1 and stay in READ. If non-zero -> SEND.
- SEND: `out_valid`=1, `out_client`=idx, `out_value`=val_q. Held stable until `out_valid`&&`out_ready`. On the handshake -> CLEAR and `sent_count`+1, saturating at 16'hffff.
- CLEAR: `dec_we`=1, `dec_index`=idx, `dec_value`=val_q for exactly one cycle. Then idx==DEPTH-1 -> DONE, otherwise idx+1 and READ.
- DONE: `done`=1 for one cycle -> IDLE.
- `start` while busy is ignored; it is not queued.
- idx never wraps. The scan ends after index DEPTH-1.
- The RAM applies mem <= mem - `dec_value`. If an accumulate lands between READ and CLEAR, the residual remains and is drained by the next scan.
- Reset at any point: state IDLE, idx=0, val_q=0, `sent_count`=0. Every output is 0, including `rd_index`. No partial `dec_we` is issued.

## Timing
- Reset value of every output is 0.
- `start` sampled at edge t -> READ during cycle t+1, `busy`=1 from t+1.
- Zero entry: 1 cycle.
- Non-zero entry with `out_ready` held high: 3 cycles (READ, SEND, CLEAR).
- Each cycle of `out_ready`=0 in SEND adds 1 cycle. `out_valid` never drops before the handshake, and `out_client`/`out_value` stay stable.
- All-zero scan: READ occupies cycles t+1..t+DEPTH, DONE at t+DEPTH+1, IDLE at t+DEPTH+2.
- `dec_we` is high only in the cycle after a handshake. `out_valid` and `dec_we` are never high together.
- Outputs are registered or decoded from state only. `out_ready` has no combinational path to `out_valid`.

## Structure
- The `cache_def` package gets `drain_state_t` (the enum above) and `drain_out_type` (packed struct: client, value).
- The accumulator RAM wrapper gains a decrement port. That change belongs to the RAM, not to this block.
- No sub-module. FSM, index counter, value register and saturating counter all live in one module.

## Test plan
- Empty RAM, `start` at cycle 0 -> no `out_valid`, `done` at cycle 1025, `sent_count`=0.
- idx3=0x10 and idx1023=0x5, `out_ready`=1 -> two transactions (3,0x10) then (1023,0x5), each followed by a matching `dec_we`; RAM all zero afterwards; `sent_count`=2.
- idx7=0x20, `out_ready` low for 5 SEND cycles -> `out_valid` held for 6 cycles, data stable, one `dec_we` of 0x20.
- idx7=0x20, accumulate +0x8 to idx7 during SEND -> sent 0x20, RAM idx7=0x8 after CLEAR, second scan sends 0x8.
- `rst` asserted mid-SEND -> all outputs 0 immediately, no `dec_we`, RAM unchanged.
- `start` pulsed while `busy` -> ignored; exactly one `done` pulse.

Source files
------------

// File: rtl/downstream_drain_pkg.sv
// Shared types for the downstream cancelled-order drain.
// drain_state_t  : scan FSM states
// drain_out_type : one {client, value} transaction as seen on the output stream
package downstream_drain_pkg;

  localparam int DRAIN_DEPTH  = 1024;
  localparam int DRAIN_IDX_W  = 10;
  localparam int DRAIN_DATA_W = 128;
  localparam int DRAIN_CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SEND,
    ST_CLEAR,
    ST_DONE
  } drain_state_t;

  typedef struct packed {
    logic [DRAIN_IDX_W-1:0]  client;
    logic [DRAIN_DATA_W-1:0] value;
  } drain_out_type;

  // Saturating increment; the counter sticks at all-ones.
  function automatic logic [DRAIN_CNT_W-1:0] sat_inc(input logic [DRAIN_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/downstream_drain_if.sv
// Bus bundle between the drain, the accumulator RAM and the reporting stream.
// RAM side   : rd_index/rd_data (combinational read), dec_we/dec_index/dec_value
// Stream side: out_valid/out_ready handshake carrying out_client/out_value
// master = drain, slave = RAM model + downstream consumer.
interface downstream_drain_if #(
  parameter int IDX_W  = 10,
  parameter int DATA_W = 128
);
  logic [IDX_W-1:0]  rd_index;
  logic [DATA_W-1:0] rd_data;
  logic              dec_we;
  logic [IDX_W-1:0]  dec_index;
  logic [DATA_W-1:0] dec_value;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_client;
  logic [DATA_W-1:0] out_value;

  modport master (
    output rd_index, input rd_data,
    output dec_we, dec_index, dec_value,
    output out_valid, input out_ready, output out_client, out_value
  );

  modport slave (
    input rd_index, output rd_data,
    input dec_we, dec_index, dec_value,
    input out_valid, output out_ready, input out_client, out_value
  );
endinterface

// File: rtl/downstream_drain.sv
// Scans every accumulator entry after a start pulse and emits each non-zero
// total as a {client, value} transaction. After the consumer accepts one, the
// exact sent amount is subtracted from the RAM, so anything accumulated while
// the entry was in flight survives for the next scan.
// Ports: clk, rst (async, active-high), start (scan request), busy, done
// (one-cycle end pulse), sent_count (accepted transactions this/last scan),
// bus (RAM read/decrement ports and output stream).
module downstream_drain
  import downstream_drain_pkg::*;
#(
  parameter int DEPTH  = DRAIN_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int DATA_W = DRAIN_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [DRAIN_CNT_W-1:0] sent_count,
  downstream_drain_if.master     bus
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  drain_state_t      state, state_d;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] val_q;

  logic is_last, rd_zero, hs;
  assign is_last = (idx == LAST);
  assign rd_zero = (bus.rd_data == '0);
  assign hs      = (state == ST_SEND) && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      val_q      <= '0;
      sent_count <= '0;
    end else begin
      state <= state_d;
      case (state)
        ST_IDLE: if (start) begin
          idx        <= '0;
          sent_count <= '0;
        end
        ST_READ: begin
          val_q <= bus.rd_data;
          if (rd_zero && !is_last) idx <= idx + 1'b1;
        end
        ST_SEND:  if (hs) sent_count <= sat_inc(sent_count);
        ST_CLEAR: if (!is_last) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (start) state_d = ST_READ;
      ST_READ:  if (!rd_zero) state_d = ST_SEND;
                else if (is_last) state_d = ST_DONE;
      ST_SEND:  if (hs) state_d = ST_CLEAR;
      ST_CLEAR: state_d = is_last ? ST_DONE : ST_READ;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are pure decodes of registered state/idx/val_q, so out_ready
  // never reaches out_valid combinationally and everything is 0 in reset.
  always_comb begin
    busy           = (state != ST_IDLE);
    done           = (state == ST_DONE);
    bus.rd_index   = (state == ST_READ)  ? idx   : '0;
    bus.out_valid  = (state == ST_SEND);
    bus.out_client = (state == ST_SEND)  ? idx   : '0;
    bus.out_value  = (state == ST_SEND)  ? val_q : '0;
    bus.dec_we     = (state == ST_CLEAR);
    bus.dec_index  = (state == ST_CLEAR) ? idx   : '0;
    bus.dec_value  = (state == ST_CLEAR) ? val_q : '0;
  end

endmodule

// File: tb/tb_downstream_drain.sv
module tb_downstream_drain;
  import downstream_drain_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic [15:0] sent_count;

  downstream_drain_if #(.IDX_W(10), .DATA_W(128)) dif ();

  downstream_drain dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .sent_count(sent_count), .bus(dif.master)
  );

  always #5 clk = ~clk;

  // Accumulator RAM model: combinational read, one writer process.
  logic [127:0] mem [1024];
  logic         mem_clr = 1'b0, wr_en = 1'b0, acc_en = 1'b0;
  logic [9:0]   wr_idx = '0, acc_idx = '0;
  logic [127:0] wr_val = '0, acc_val = '0;

  assign dif.rd_data = mem[dif.rd_index];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else begin
      if (wr_en)  mem[wr_idx]  <= wr_val;
      if (acc_en) mem[acc_idx] <= mem[acc_idx] + acc_val;
      if (dif.dec_we) mem[dif.dec_index] <= mem[dif.dec_index] - dif.dec_value;
    end
  end

  // Monotonic monitor; tests compare against snapshots.
  int cyc = 0, vcyc = 0, ndone = 0, overlap = 0;
  drain_out_type tx_q[$], dec_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (dif.out_valid) vcyc++;
      if (dif.out_valid && dif.out_ready) tx_q.push_back('{client: dif.out_client, value: dif.out_value});
      if (dif.dec_we) dec_q.push_back('{client: dif.dec_index, value: dif.dec_value});
      if (dif.dec_we && dif.out_valid) overlap++;
      if (done) ndone++;
    end
  end

  int tests = 0, fails = 0;
  int t0, n, tx0, dec0, v0, d0;
  logic [9:0]   ref_c;
  logic [127:0] ref_v;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    @(negedge clk); mem_clr = 1'b1;
    @(posedge clk); #1 mem_clr = 1'b0;
  endtask

  task automatic poke(input logic [9:0] i, input logic [127:0] v);
    @(negedge clk); wr_en = 1'b1; wr_idx = i; wr_val = v;
    @(posedge clk); #1 wr_en = 1'b0;
  endtask

  task automatic snap();
    tx0 = tx_q.size(); dec0 = dec_q.size(); v0 = vcyc; d0 = ndone;
  endtask

  // Pulse start so it is sampled at one edge; t0 = cyc just after that edge.
  task automatic kick();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0; t0 = cyc;
  endtask

  task automatic wait_valid();
    while (!dif.out_valid && (cyc - t0) < 3000) begin @(posedge clk); #1; end
    chk("wait_valid", dif.out_valid, 1);
  endtask

  // n = 1 is the first cycle after the start edge.
  task automatic wait_done(output int nn);
    while (!done && (cyc - t0) < 3000) begin @(posedge clk); #1; end
    chk("wait_done", done, 1);
    nn = cyc - t0 + 1;
  endtask

  initial begin
    dif.out_ready = 1'b1;
    // reset state while RAM is cleared
    clear_mem();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", dif.out_valid, 0);
    chk("rst_dec_we", dif.dec_we, 0);
    chk("rst_rd_index", dif.rd_index, 0);
    chk("rst_sent", sent_count, 0);
    @(negedge clk); rst = 1'b0;

    // 1: empty RAM
    snap(); kick();
    chk("empty_busy_t1", busy, 1);
    chk("empty_rd_index0", dif.rd_index, 0);
    wait_done(n);
    chk("empty_done_cycle", n, 1025);
    chk("empty_no_tx", tx_q.size() - tx0, 0);
    chk("empty_sent", sent_count, 0);
    @(posedge clk); #1;
    chk("empty_idle_busy", busy, 0);
    chk("empty_done_pulse", done, 0);

    // 2: idx3=0x10, idx1023=0x5, ready high
    poke(10'd3, 128'h10); poke(10'd1023, 128'h5);
    snap(); dif.out_ready = 1'b1; kick(); wait_done(n);
    chk("two_done_cycle", n, 1029);
    chk("two_tx_cnt", tx_q.size() - tx0, 2);
    chk("two_tx0_c", tx_q[tx0].client, 3);
    chk("two_tx0_v", tx_q[tx0].value, 128'h10);
    chk("two_tx1_c", tx_q[tx0+1].client, 1023);
    chk("two_tx1_v", tx_q[tx0+1].value, 128'h5);
    chk("two_dec_cnt", dec_q.size() - dec0, 2);
    chk("two_dec0", dec_q[dec0], {10'd3, 128'h10});
    chk("two_dec1", dec_q[dec0+1], {10'd1023, 128'h5});
    @(posedge clk); #1;
    chk("two_mem3", mem[3], 0);
    chk("two_mem1023", mem[1023], 0);
    chk("two_sent", sent_count, 2);
    chk("two_overlap", overlap, 0);

    // 3: backpressure, ready low for 5 SEND cycles
    poke(10'd7, 128'h20);
    snap(); dif.out_ready = 1'b0; kick(); wait_valid();
    ref_c = dif.out_client; ref_v = dif.out_value;
    chk("stall_client", ref_c, 7);
    chk("stall_value", ref_v, 128'h20);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid_held", dif.out_valid, 1);
      chk("stall_client_stable", dif.out_client, ref_c);
      chk("stall_value_stable", dif.out_value, ref_v);
      chk("stall_no_dec", dif.dec_we, 0);
    end
    dif.out_ready = 1'b1;
    wait_done(n);
    chk("stall_done_cycle", n, 1032);
    chk("stall_valid_cycles", vcyc - v0, 6);
    chk("stall_dec_cnt", dec_q.size() - dec0, 1);
    chk("stall_dec", dec_q[dec0], {10'd7, 128'h20});
    @(posedge clk); #1;
    chk("stall_mem7", mem[7], 0);

    // 4: accumulate races the drain
    poke(10'd7, 128'h20);
    snap(); dif.out_ready = 1'b0; kick(); wait_valid();
    acc_en = 1'b1; acc_idx = 10'd7; acc_val = 128'h8;
    @(posedge clk); #1 acc_en = 1'b0;
    chk("race_value_held", dif.out_value, 128'h20);
    dif.out_ready = 1'b1;
    wait_done(n);
    chk("race_tx_v", tx_q[tx0].value, 128'h20);
    chk("race_dec", dec_q[dec0], {10'd7, 128'h20});
    @(posedge clk); #1;
    chk("race_mem7_residual", mem[7], 128'h8);
    snap(); kick(); wait_done(n);
    chk("race2_tx_cnt", tx_q.size() - tx0, 1);
    chk("race2_tx", tx_q[tx0], {10'd7, 128'h8});
    chk("race2_sent", sent_count, 1);
    @(posedge clk); #1;
    chk("race2_mem7", mem[7], 0);

    // 5: reset mid-SEND
    poke(10'd7, 128'h20);
    snap(); dif.out_ready = 1'b0; kick(); wait_valid();
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", dif.out_valid, 0);
    chk("mrst_value", dif.out_value, 0);
    chk("mrst_client", dif.out_client, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_dec_we", dif.dec_we, 0);
    chk("mrst_sent", sent_count, 0);
    chk("mrst_rd_index", dif.rd_index, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_no_dec", dec_q.size() - dec0, 0);
    chk("mrst_mem7", mem[7], 128'h20);
    @(negedge clk); rst = 1'b0;
    dif.out_ready = 1'b1;

    // 6: start while busy is ignored
    clear_mem();
    snap(); kick();
    repeat (10) @(posedge clk);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("ign_busy", busy, 1);
    wait_done(n);
    chk("ign_done_cycle", n, 1025);
    repeat (5) @(posedge clk);
    #1;
    chk("ign_one_done", ndone - d0, 1);
    chk("ign_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
